// File: rtl/key_trial_checker.sv
`default_nettype none
// ============================================================================
// Module   : key_trial_checker
// Purpose  : Worker side of the key search. Each high period of reset_all is
//            one key trial. The checker captures secret_key, starts the RC4
//            decrypt core with a start/done handshake, then scans the decrypted
//            message RAM for legal plaintext. The result goes back to the key
//            controller as a one-cycle failure pulse or a sticky success level.
// Ports    : clk         system clock, rising edge
//            reset       asynchronous active-low reset
//            reset_all   trial enable; low aborts/clears, high runs/holds
//            secret_key  key under test, sampled only in IDLE
//            failure     one-cycle pulse, illegal byte found
//            success     level, all bytes legal (held while reset_all high)
//            found_key   passing key while success is high, else 0
//            dec_start   one-cycle start pulse to the decrypt core
//            dec_key     key presented to the decrypt core
//            dec_done    decrypt core finished (sampled only in WAIT_DONE)
//            msg_addr    message RAM read address
//            msg_rdata   message RAM data, one cycle after msg_addr
// Config   : CHECK_UPPERCASE_EN - when defined, 'A'..'Z' are also legal.
// Params   : MSG_LEN bytes checked; ADDR_W address width (MSG_LEN <= 2**ADDR_W)
// Revision : 1.0 - initial release
// ============================================================================
module key_trial_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_all,
  input  logic [23:0]       secret_key,
  output logic              failure,
  output logic              success,
  output logic [23:0]       found_key,
  output logic              dec_start,
  output logic [23:0]       dec_key,
  input  logic              dec_done,
  output logic [ADDR_W-1:0] msg_addr,
  input  logic [7:0]        msg_rdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_READ      = 3'd3,
    S_CHECK     = 3'd4,
    S_FAIL      = 3'd5,
    S_PASS      = 3'd6,
    S_HOLD      = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [23:0]       dec_key_nxt;
  logic [23:0]       found_key_nxt;
  logic              dec_start_nxt;
  logic              failure_nxt;
  logic              success_nxt;
  logic              done, done_nxt;

  function automatic logic is_legal(input logic [7:0] b);
    logic ok;
    ok = ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
`ifdef CHECK_UPPERCASE_EN
    ok = ok || ((b >= 8'h41) && (b <= 8'h5A));
`endif
    return ok;
  endfunction

  // The index register doubles as the RAM address: it already holds the
  // byte number when READ is entered, so the address is registered for free.
  assign msg_addr = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      dec_key   <= '0;
      found_key <= '0;
      dec_start <= 1'b0;
      failure   <= 1'b0;
      success   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      dec_key   <= dec_key_nxt;
      found_key <= found_key_nxt;
      dec_start <= dec_start_nxt;
      failure   <= failure_nxt;
      success   <= success_nxt;
      done      <= done_nxt;
    end
  end

  // Output pulses are computed one state ahead so that each registered output
  // is high during the state it belongs to (dec_start in START, failure in
  // FAIL, success from PASS onward).
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    dec_key_nxt   = dec_key;
    found_key_nxt = found_key;
    dec_start_nxt = 1'b0;
    failure_nxt   = 1'b0;
    success_nxt   = success;
    done_nxt      = done;

    if (!reset_all) begin
      // Abort/clear takes priority over everything, including a dec_done
      // arriving in the same cycle and a failure about to be issued.
      state_nxt     = S_IDLE;
      success_nxt   = 1'b0;
      found_key_nxt = '0;
      done_nxt      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!done) begin
            dec_key_nxt   = secret_key;
            idx_nxt       = '0;
            dec_start_nxt = 1'b1;
            state_nxt     = S_START;
          end
        end
        S_START: begin
          state_nxt = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (dec_done) begin
            state_nxt = S_READ;
          end
        end
        S_READ: begin
          state_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (!is_legal(msg_rdata)) begin
            failure_nxt = 1'b1;
            state_nxt   = S_FAIL;
          end else if (idx == LAST_IDX) begin
            // Index stops at the last byte, so it never wraps even when
            // MSG_LEN fills the whole address space.
            success_nxt   = 1'b1;
            found_key_nxt = dec_key;
            state_nxt     = S_PASS;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_READ;
          end
        end
        S_FAIL: begin
          done_nxt  = 1'b1;
          state_nxt = S_HOLD;
        end
        S_PASS: begin
          done_nxt  = 1'b1;
          state_nxt = S_HOLD;
        end
        S_HOLD: begin
          state_nxt = S_HOLD;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_trial_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_trial_checker
// Purpose  : Self-checking bench for key_trial_checker. Drives whole key
//            trials, models the message RAM and the decrypt handshake, and
//            compares every cycle of every trial against expectations derived
//            from the timing rules (result cycle from first illegal byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_trial_checker;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
`ifdef CHECK_UPPERCASE_EN
  localparam int UC_K = MSG_LEN;
`else
  localparam int UC_K = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              reset_all;
  logic [23:0]       secret_key;
  logic              failure;
  logic              success;
  logic [23:0]       found_key;
  logic              dec_start;
  logic [23:0]       dec_key;
  logic              dec_done;
  logic [ADDR_W-1:0] msg_addr;
  logic [7:0]        msg_rdata;

  logic [7:0] mem [MSG_LEN];

  int n_pass  = 0;
  int n_total = 0;

  key_trial_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_all  (reset_all),
    .secret_key (secret_key),
    .failure    (failure),
    .success    (success),
    .found_key  (found_key),
    .dec_start  (dec_start),
    .dec_key    (dec_key),
    .dec_done   (dec_done),
    .msg_addr   (msg_addr),
    .msg_rdata  (msg_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read message RAM
  always @(posedge clk) msg_rdata <= mem[msg_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference plaintext rule
  function automatic bit ref_legal(input logic [7:0] b);
    bit ok;
    ok = (b == 8'h20) || (b inside {[8'h61:8'h7A]});
`ifdef CHECK_UPPERCASE_EN
    ok = ok || (b inside {[8'h41:8'h5A]});
`endif
    return ok;
  endfunction

  function automatic int ref_first_bad();
    for (int i = 0; i < MSG_LEN; i++) if (!ref_legal(mem[i])) return i;
    return MSG_LEN;
  endfunction

  function automatic int result_cycle(input int delay, input int k);
    int t;
    t = 2 + delay;
    return (k < MSG_LEN) ? t + 3 + 2 * k : t + 2 * MSG_LEN + 1;
  endfunction

  // One trial. Cycle 0 is the cycle in which reset_all is first sampled high;
  // dec_done is sampled high in cycle 2+delay. abort_at >= 0 drops reset_all
  // so it is sampled low in that cycle. k is the expected first illegal byte
  // (MSG_LEN for a fully legal message).
  task automatic run_trial(input logic [23:0] key, input int delay, input int k,
                           input int abort_at, input bit noise);
    int  t, res, last;
    bit  alive, e_start, e_fail, e_succ;
    t    = 2 + delay;
    res  = result_cycle(delay, k);
    last = (abort_at >= 0) ? abort_at + 3 : res + 3;
    @(negedge clk);
    secret_key = key;
    reset_all  = 1'b1;
    dec_done   = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      alive   = (abort_at < 0) || (cyc <= abort_at);
      e_start = alive && (cyc == 1);
      e_fail  = alive && (k < MSG_LEN) && (cyc == res);
      e_succ  = alive && (k == MSG_LEN) && (cyc >= res);
      chk("dec_start", 32'(dec_start), 32'(e_start));
      chk("failure",   32'(failure),   32'(e_fail));
      chk("success",   32'(success),   32'(e_succ));
      chk("found_key", 32'(found_key), e_succ ? 32'(key) : 32'h0);
      if (alive && cyc <= t)
        chk("dec_key", 32'(dec_key), 32'(key));
      if (alive && cyc > t && cyc <= res - 2 && ((cyc - t - 1) % 2 == 0))
        chk("msg_addr", 32'(msg_addr), 32'((cyc - t - 1) / 2));
      secret_key = 24'($urandom);
      dec_done   = (cyc == t) ||
                   (noise && (cyc == 1 || cyc > t) && ($urandom_range(0, 1) == 1));
      reset_all  = !(abort_at >= 0 && cyc >= abort_at);
    end
    if (abort_at < 0) begin
      reset_all = 1'b0;
      @(negedge clk);
      chk("success_clear",   32'(success),   32'h0);
      chk("found_key_clear", 32'(found_key), 32'h0);
      chk("failure_clear",   32'(failure),   32'h0);
    end
    dec_done = 1'b0;
    @(negedge clk);
    chk("no_restart_low", 32'(dec_start), 32'h0);
  endtask

  task automatic fill_mem(input logic [7:0] fill, input int bad_idx, input logic [7:0] bad_byte);
    for (int i = 0; i < MSG_LEN; i++) mem[i] = fill;
    if (bad_idx >= 0) mem[bad_idx] = bad_byte;
  endtask

  task automatic idle(input int n);
    reset_all = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] fill;
    int         bad_idx;
    logic [7:0] bad_byte;
    int         delay;
    int         exp_k;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k, d, res, ab;
    reset      = 1'b1;
    reset_all  = 1'b0;
    secret_key = 24'h0;
    dec_done   = 1'b0;
    fill_mem(8'h61, -1, 8'h00);
    #1 reset = 1'b0;
    #3;
    chk("rst_failure",   32'(failure),   32'h0);
    chk("rst_success",   32'(success),   32'h0);
    chk("rst_found_key", 32'(found_key), 32'h0);
    chk("rst_dec_start", 32'(dec_start), 32'h0);
    chk("rst_dec_key",   32'(dec_key),   32'h0);
    chk("rst_msg_addr",  32'(msg_addr),  32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    vecs[0] = '{8'h61,  5, 8'h2E, 0, 5};        // key 0: failure at T+13
    vecs[1] = '{8'h61, -1, 8'h00, 0, MSG_LEN};  // key 1: success at T+65
    vecs[2] = '{8'h20,  0, 8'h00, 3, 0};
    vecs[3] = '{8'h7A, 31, 8'h7B, 1, 31};
    vecs[4] = '{8'h61, 31, 8'h60, 2, 31};
    vecs[5] = '{8'h61,  0, 8'h41, 0, UC_K};     // uppercase first byte
    vecs[6] = '{8'h20, -1, 8'h00, 4, MSG_LEN};
    vecs[7] = '{8'h62, 10, 8'h5B, 0, 10};
    vecs[8] = '{8'h79, 15, 8'h40, 1, 15};
    vecs[9] = '{8'h20, 30, 8'h1F, 2, 30};

    for (int i = 0; i < 10; i++) begin
      fill_mem(vecs[i].fill, vecs[i].bad_idx, vecs[i].bad_byte);
      run_trial(24'(i), vecs[i].delay, vecs[i].exp_k, -1, 1'b0);
      idle(3);
    end

    // Abort during CHECK of byte 10 (byte 10 illegal): nothing reported
    fill_mem(8'h61, 10, 8'h2E);
    run_trial(24'h00A5A5, 0, 10, 2 + 2 + 20, 1'b0);
    run_trial(24'h00A5A6, 0, 10, -1, 1'b0);
    idle(2);

    // Abort in the very cycle dec_done arrives: back to IDLE, no scan
    fill_mem(8'h61, 0, 8'h00);
    run_trial(24'h123456, 2, 0, 4, 1'b0);
    run_trial(24'h123457, 1, 0, -1, 1'b0);
    idle(2);

    // Asynchronous reset in READ of byte 2
    fill_mem(8'h61, -1, 8'h00);
    @(negedge clk);
    secret_key = 24'hABCDEF;
    reset_all  = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      dec_done = (cyc == 2);
    end
    chk("pre_async_addr", 32'(msg_addr), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("async_dec_key",  32'(dec_key),   32'h0);
    chk("async_msg_addr", 32'(msg_addr),  32'h0);
    chk("async_success",  32'(success),   32'h0);
    chk("async_failure",  32'(failure),   32'h0);
    chk("async_found",    32'(found_key), 32'h0);
    chk("async_start",    32'(dec_start), 32'h0);
    dec_done  = 1'b0;
    reset_all = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomized trials against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if ($urandom_range(0, 40) == 0) mem[i] = 8'($urandom_range(0, 255));
        else begin
          d = $urandom_range(0, 26);
          mem[i] = (d == 26) ? 8'h20 : 8'(8'h61 + d);
        end
      end
      k   = ref_first_bad();
      d   = $urandom_range(0, 5);
      res = result_cycle(d, k);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, res + 2) : -1;
      run_trial(24'($urandom), d, k, ab, 1'b1);
      idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
